// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the decoder.
// Holds the PC, issues one 32-bit fetch at a time on a req/resp bus and presents
// the fetched word to the decoder with valid/ready. Execute may redirect the PC at
// any time; a response already in flight for the old PC is tracked by drop_q and
// thrown away when it arrives.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a target with bits [1:0] != 0 parks fetch in FAULT
//               with fetch_fault=1 until an aligned redirect or reset.
//   undefined : redirect targets are forced word-aligned, FAULT is unreachable and
//               fetch_fault is tied low.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one-cycle settle after reset, no request
// REQ   | request for pc driven on the bus, waiting for ireq_ready
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction presented to decoder, waiting for inst_ready
// FAULT | misaligned redirect trapped, fetch stalled (trap build only)

module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            ireq_ready,
  input  logic            iresp_valid,
  input  logic [31:0]     iresp_data,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic            drop_q;
  logic            inst_valid_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;

  logic [XLEN-1:0] redir_tgt_d;
  logic [XLEN-1:0] pc_inc_d;
  logic            redir_misaligned_d;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            fault_q;
`endif

  // Redirect target and sequential PC; the alignment treatment depends on the build.
  always_comb begin
    redir_tgt_d        = redirect_pc;
    redir_misaligned_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    redir_misaligned_d = (redirect_pc[1:0] != 2'b00);
`else
    redir_tgt_d[1:0]   = 2'b00;
`endif
    pc_inc_d = pc_q + XLEN'(4);
  end

  // Fetch FSM; redirect outranks every other event in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q      <= 1'b0;
`endif
    end else if (redirect_valid) begin
      pc_q         <= redir_tgt_d;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      // Outstanding-request bookkeeping is the same whether or not the target traps.
      case (state_q)
        S_REQ: begin
          if (ireq_ready) begin
            // The old-pc request is accepted this very cycle, so its response is stale.
            state_q <= S_WAIT;
            drop_q  <= 1'b1;
          end else begin
            state_q <= S_REQ;
          end
        end
        S_WAIT: begin
          if (iresp_valid) begin
            drop_q  <= 1'b0;
            state_q <= S_REQ;
          end else begin
            drop_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_FAULT: begin
          if (iresp_valid && drop_q) begin
            drop_q <= 1'b0;
          end
          state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= redir_misaligned_d;
      if (redir_misaligned_d) begin
        state_q <= S_FAULT;
      end
`endif
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (ireq_ready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (iresp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              inst_q       <= iresp_data;
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
              pc_q         <= pc_inc_d;
              state_q      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            state_q      <= S_REQ;
          end
        end
        S_FAULT: begin
          // A stale response may still land while parked; retire it here so the
          // first fetch after leaving FAULT is not mistaken for it.
          if (iresp_valid && drop_q) begin
            drop_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs are direct decodes of registered state.
  assign ireq_valid = (state_q == S_REQ);
  assign ireq_addr  = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // redir_misaligned_d only steers the FSM in the trap build.
  logic unused_d;
  assign unused_d = redir_misaligned_d;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Honours FETCH_MISALIGN_TRAP_EN for the misaligned-redirect vector.

module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .ireq_ready     (ireq_ready),
    .iresp_valid    (iresp_valid),
    .iresp_data     (iresp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-latency fetch of one word starting in REQ at exp_pc, consumed at once.
  task automatic fetch_one(input string tag, input logic [31:0] data, input logic [63:0] exp_pc);
    chk({tag, "_req_valid"}, {63'd0, ireq_valid}, 64'd1);
    chk({tag, "_req_addr"}, ireq_addr, exp_pc);
    ireq_ready = 1'b1;
    step();
    ireq_ready  = 1'b0;
    iresp_valid = 1'b1;
    iresp_data  = data;
    step();
    iresp_valid = 1'b0;
    chk({tag, "_inst_valid"}, {63'd0, inst_valid}, 64'd1);
    chk({tag, "_inst"}, {32'd0, inst}, {32'd0, data});
    chk({tag, "_inst_pc"}, inst_pc, exp_pc);
    chk({tag, "_hold_noreq"}, {63'd0, ireq_valid}, 64'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk({tag, "_rel_valid"}, {63'd0, inst_valid}, 64'd0);
    chk({tag, "_rel_nop"}, {32'd0, inst}, {32'd0, NOP});
    chk({tag, "_next_req"}, {63'd0, ireq_valid}, 64'd1);
    chk({tag, "_next_addr"}, ireq_addr, exp_pc + 64'd4);
  endtask

  initial begin
    reset          = 1'b1;
    ireq_ready     = 1'b0;
    iresp_valid    = 1'b0;
    iresp_data     = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;

    // 1: reset state and first request
    step();
    step();
    chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst_ireq_addr", ireq_addr, 64'h8000_0000);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst", {32'd0, inst}, {32'd0, NOP});
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_fault", {63'd0, fetch_fault}, 64'd0);
    reset = 1'b0;
    chk("idle_noreq", {63'd0, ireq_valid}, 64'd0);
    step();
    chk("req_after_idle", {63'd0, ireq_valid}, 64'd1);
    chk("req_addr_reset_pc", ireq_addr, 64'h8000_0000);
    chk("req_inst_nop", {32'd0, inst}, {32'd0, NOP});

    // 2: two back-to-back fetches, 3 cycles each
    fetch_one("t2a", 32'h0050_0093, 64'h8000_0000);
    fetch_one("t2b", 32'h00A0_0113, 64'h8000_0004);

    // 3: decoder stalls for 4 cycles in HOLD
    ireq_ready = 1'b1;
    step();
    ireq_ready  = 1'b0;
    iresp_valid = 1'b1;
    iresp_data  = 32'h1234_5678;
    step();
    iresp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold_valid", {63'd0, inst_valid}, 64'd1);
      chk("t3_hold_inst", {32'd0, inst}, 64'h1234_5678);
      chk("t3_hold_pc", inst_pc, 64'h8000_0008);
      chk("t3_hold_noreq", {63'd0, ireq_valid}, 64'd0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("t3_rel_req", {63'd0, ireq_valid}, 64'd1);
    chk("t3_rel_addr", ireq_addr, 64'h8000_000C);
    chk("t3_rel_valid", {63'd0, inst_valid}, 64'd0);

    // 4: redirect in WAIT, stale response two cycles later is dropped
    ireq_ready = 1'b1;
    step();
    ireq_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    chk("t4_wait_noreq", {63'd0, ireq_valid}, 64'd0);
    step();
    chk("t4_wait_noreq2", {63'd0, ireq_valid}, 64'd0);
    iresp_valid = 1'b1;
    iresp_data  = 32'hDEAD_BEEF;
    step();
    iresp_valid = 1'b0;
    chk("t4_drop_valid", {63'd0, inst_valid}, 64'd0);
    chk("t4_drop_inst", {32'd0, inst}, {32'd0, NOP});
    chk("t4_req_valid", {63'd0, ireq_valid}, 64'd1);
    chk("t4_req_addr", ireq_addr, 64'h8000_0100);
    fetch_one("t4_next", 32'h0010_8093, 64'h8000_0100);

    // 5: redirect in REQ without ready, fetch at top of address space, pc wraps
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    fetch_one("t5_wrap", 32'h0020_0193, 64'hFFFF_FFFF_FFFF_FFFC);

    // reset mid-transaction, late response ignored
    ireq_ready = 1'b1;
    step();
    ireq_ready = 1'b0;
    reset      = 1'b1;
    step();
    reset       = 1'b0;
    iresp_valid = 1'b1;
    iresp_data  = 32'hBAD0_0BAD;
    step();
    iresp_valid = 1'b0;
    chk("rst_mid_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_mid_inst", {32'd0, inst}, {32'd0, NOP});
    fetch_one("rst_mid_fetch", 32'h0030_0213, 64'h8000_0000);

    // redirect in HOLD beats inst_ready
    ireq_ready = 1'b1;
    step();
    ireq_ready  = 1'b0;
    iresp_valid = 1'b1;
    iresp_data  = 32'h0040_0293;
    step();
    iresp_valid    = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    step();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    chk("t7_hold_redir_valid", {63'd0, inst_valid}, 64'd0);
    chk("t7_hold_redir_req", {63'd0, ireq_valid}, 64'd1);
    chk("t7_hold_redir_addr", ireq_addr, 64'h8000_0300);

    // redirect coinciding with the response in WAIT
    ireq_ready = 1'b1;
    step();
    ireq_ready     = 1'b0;
    iresp_valid    = 1'b1;
    iresp_data     = 32'hAAAA_5555;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0400;
    step();
    iresp_valid    = 1'b0;
    redirect_valid = 1'b0;
    chk("t7_wait_redir_valid", {63'd0, inst_valid}, 64'd0);
    chk("t7_wait_redir_inst", {32'd0, inst}, {32'd0, NOP});
    fetch_one("t7_after", 32'h0050_0313, 64'h8000_0400);

    // 6: misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      chk("t6_fault", {63'd0, fetch_fault}, 64'd1);
      chk("t6_fault_noreq", {63'd0, ireq_valid}, 64'd0);
      chk("t6_fault_novalid", {63'd0, inst_valid}, 64'd0);
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    chk("t6_fault_clr", {63'd0, fetch_fault}, 64'd0);
    fetch_one("t6_after", 32'h0060_0393, 64'h8000_0200);
`else
    chk("t6_nofault", {63'd0, fetch_fault}, 64'd0);
    fetch_one("t6_aligned", 32'h0060_0393, 64'h8000_0100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
